// File: rtl/fp16_tile_reduce_stream_pkg.sv
// Shared definitions for the FP16 tile reducer: element width, zero
// constant, default adder latency and the run-control state encoding.
package fp16_tile_reduce_stream_pkg;

  localparam int                FP16_W       = 16;
  localparam logic [FP16_W-1:0] FP16_ZERO    = 16'h0000;
  localparam int                FP16_ADD_LAT = 11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    FLUSH = 3'd4
  } state_e;

endpackage

// File: rtl/fp16_tile_reduce_stream_if.sv
// Tile input / result output handshake bundle.
//   in_valid/in_ready/in_data : one tile of N FP16 elements, element i at [(i+1)*DW-1 -: DW]
//   out_valid/out_ready       : result FIFO head handshake
//   out_data/out_last         : tile sum, final-tile-of-run flag
// master = tile producer and result consumer, slave = the reducer.
interface fp16_tile_reduce_stream_if
  import fp16_tile_reduce_stream_pkg::*;
#(
  parameter int N  = 128,
  parameter int DW = FP16_W
) ();
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_last;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_last);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/fp16_tile_reduce_stream_tree.sv
// fp16_add_wrapper: binary16 adder, round-to-nearest-even, subnormals kept,
//   NaN on NaN input or Inf-Inf, overflow to Inf; result after ADD_LAT clocks.
//   Ports: clk, a_i, b_i -> sum_o.
// fp16_adder_tree: pairwise reduction of N elements over $clog2(N) adder levels
//   with a valid bit shifted alongside. Never stalls.
//   Ports: clk, rst, vld_i/data_i (N*DW) -> vld_o/data_o (DW).
module fp16_add_wrapper
  import fp16_tile_reduce_stream_pkg::*;
#(
  parameter int ADD_LAT = FP16_ADD_LAT
) (
  input  logic              clk,
  input  logic [FP16_W-1:0] a_i,
  input  logic [FP16_W-1:0] b_i,
  output logic [FP16_W-1:0] sum_o
);

  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] big, sml;
    logic [10:0] mb, ms;
    logic [4:0]  eb, es, d;
    logic [13:0] xs, mask, m;
    logic [14:0] sum;
    logic [5:0]  e;
    logic [11:0] mr;
    logic        sticky, rnd, a_nan, b_nan, a_inf, b_inf;
    a_nan = (&a[14:10]) && (|a[9:0]);
    b_nan = (&b[14:10]) && (|b[9:0]);
    a_inf = (&a[14:10]) && !(|a[9:0]);
    b_inf = (&b[14:10]) && !(|b[9:0]);
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) return 16'h7E00;
    if (a_inf) return a;
    if (b_inf) return b;
    // Larger magnitude first so the aligned difference never goes negative.
    if (a[14:0] >= b[14:0]) begin big = a; sml = b; end
    else                    begin big = b; sml = a; end
    eb = (big[14:10] == 5'd0) ? 5'd1 : big[14:10];
    es = (sml[14:10] == 5'd0) ? 5'd1 : sml[14:10];
    mb = {|big[14:10], big[9:0]};
    ms = {|sml[14:10], sml[9:0]};
    d  = eb - es;
    // Three guard bits; everything shifted past them folds into the sticky LSB.
    xs = {ms, 3'b000};
    if (d > 5'd13) begin
      sticky = |ms;
      xs     = '0;
    end else begin
      mask   = (14'd1 << d) - 14'd1;
      sticky = |(xs & mask);
      xs     = xs >> d;
    end
    xs[0] = xs[0] | sticky;
    if (big[15] == sml[15]) sum = {1'b0, mb, 3'b000} + {1'b0, xs};
    else                    sum = {1'b0, mb, 3'b000} - {1'b0, xs};
    if (sum == 15'd0) return {big[15] & sml[15], 15'h0000};
    e = {1'b0, eb};
    if (sum[14]) begin
      m = sum[14:1] | {13'b0, sum[0]};
      e = e + 6'd1;
    end else begin
      m = sum[13:0];
      // Normalise left, but never below the subnormal exponent.
      for (int i = 0; i < 13; i++) begin
        if (!m[13] && (e > 6'd1)) begin
          m = m << 1;
          e = e - 6'd1;
        end
      end
    end
    rnd = m[2] & (m[1] | m[0] | m[3]);
    mr  = {1'b0, m[13:3]} + {11'b0, rnd};
    if (mr[11]) begin
      mr = mr >> 1;
      e  = e + 6'd1;
    end
    if (e >= 6'd31) return {big[15], 5'h1F, 10'h000};
    return {big[15], (mr[10] ? e[4:0] : 5'd0), mr[9:0]};
  endfunction

  logic [ADD_LAT-1:0][FP16_W-1:0] pipe_q;

  // Stage 0: sum computed and captured; later stages only delay it.
  always_ff @(posedge clk) begin
    pipe_q[0] <= fp16_add(a_i, b_i);
    for (int s = 1; s < ADD_LAT; s++) pipe_q[s] <= pipe_q[s-1];
  end

  assign sum_o = pipe_q[ADD_LAT-1];

endmodule

module fp16_adder_tree
  import fp16_tile_reduce_stream_pkg::*;
#(
  parameter int N       = 128,
  parameter int DW      = FP16_W,
  parameter int ADD_LAT = FP16_ADD_LAT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vld_i,
  input  logic [N*DW-1:0] data_i,
  output logic            vld_o,
  output logic [DW-1:0]   data_o
);

  localparam int TREE_DEPTH = $clog2(N);
  localparam int TREE_LAT   = ADD_LAT * TREE_DEPTH;

  // All tree nodes, level by level: level l starts at 2N - 2*(N>>l).
  logic [2*N-2:0][DW-1:0] node;
  logic [TREE_LAT-1:0]    vld_q;

  for (genvar i = 0; i < N; i++) begin : g_leaf
    assign node[i] = data_i[(i+1)*DW-1 -: DW];
  end

  // Level l adds neighbours (2j, 2j+1) of level l-1, fixing the summation order.
  for (genvar l = 1; l <= TREE_DEPTH; l++) begin : g_lvl
    for (genvar j = 0; j < (N >> l); j++) begin : g_add
      fp16_add_wrapper #(.ADD_LAT(ADD_LAT)) u_add (
        .clk   (clk),
        .a_i   (node[2*N - 2*(N >> (l-1)) + 2*j]),
        .b_i   (node[2*N - 2*(N >> (l-1)) + 2*j + 1]),
        .sum_o (node[2*N - 2*(N >> l) + j])
      );
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      for (int s = 1; s < TREE_LAT; s++) vld_q[s] <= vld_q[s-1];
    end
  end

  assign vld_o  = vld_q[TREE_LAT-1];
  assign data_o = node[2*N-2];

endmodule

// File: rtl/fp16_tile_reduce_stream.sv
// Streaming FP16 row reducer. Each accepted tile of N elements is registered,
// summed by a non-stalling adder tree and written into a first-word-fall-through
// result FIFO. Credits (one per free FIFO slot) gate in_ready so a tree result
// always has space. abort drops the run; results still in the tree are counted
// down in FLUSH and discarded.
// Ports: clk, rst (async, active-high); start/cfg_tiles begin a run; abort;
//   bus (slave) tile in / result out handshakes; busy (RUN/DRAIN/FLUSH); done pulse.
module fp16_tile_reduce_stream
  import fp16_tile_reduce_stream_pkg::*;
#(
  parameter int N          = 128,
  parameter int DW         = FP16_W,
  parameter int ADD_LAT    = FP16_ADD_LAT,
  parameter int MAX_TILES  = 64,
  parameter int FIFO_DEPTH = 8,
  localparam int TW        = $clog2(MAX_TILES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [TW-1:0]               cfg_tiles,
  input  logic                        abort,
  fp16_tile_reduce_stream_if.slave    bus,
  output logic                        busy,
  output logic                        done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   tiles_q, tiles_d, tiles_in_q, tiles_in_d;
  logic [TW-1:0]   tiles_wr_q, tiles_wr_d, tiles_pop_q, tiles_pop_d, cfg_clamp;
  logic [CW-1:0]   credits_q, credits_d, inflight_q, inflight_d, discard_q, discard_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [N*DW-1:0] tile_q;
  logic            tile_vld_q;
  logic            tree_vld;
  logic [DW-1:0]   tree_data;
  logic [DW-1:0]   mem_q  [FIFO_DEPTH];
  logic            last_q [FIFO_DEPTH];
  logic            accept, pop, wr, abort_eff, last_wr;

  assign abort_eff = abort && (state_q != IDLE) && (state_q != DONE);
  assign cfg_clamp = (cfg_tiles > TW'(MAX_TILES)) ? TW'(MAX_TILES) : cfg_tiles;

  assign bus.in_ready  = (state_q == RUN) && (tiles_in_q < tiles_q) && (credits_q != '0);
  assign bus.out_valid = (wr_ptr_q != rd_ptr_q);
  assign bus.out_data  = bus.out_valid ? mem_q[rd_ptr_q[AW-1:0]] : FP16_ZERO;
  assign bus.out_last  = bus.out_valid && last_q[rd_ptr_q[AW-1:0]];
  assign busy          = (state_q == RUN) || (state_q == DRAIN) || (state_q == FLUSH);
  assign done          = (state_q == DONE);

  assign accept  = bus.in_valid && bus.in_ready && !abort_eff;
  assign pop     = bus.out_valid && bus.out_ready && !abort_eff;
  assign wr      = tree_vld && ((state_q == RUN) || (state_q == DRAIN)) && !abort_eff;
  assign last_wr = ((tiles_wr_q + TW'(1)) == tiles_q);

  always_comb begin
    state_d     = state_q;
    tiles_d     = tiles_q;
    tiles_in_d  = tiles_in_q;
    tiles_wr_d  = tiles_wr_q;
    tiles_pop_d = tiles_pop_q;
    credits_d   = credits_q;
    inflight_d  = inflight_q;
    discard_d   = discard_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    if (accept) tiles_in_d = tiles_in_q + TW'(1);
    if (wr) begin
      tiles_wr_d = tiles_wr_q + TW'(1);
      wr_ptr_d   = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      tiles_pop_d = tiles_pop_q + TW'(1);
      rd_ptr_d    = rd_ptr_q + (AW+1)'(1);
    end
    if (accept && !pop)      credits_d = credits_q - CW'(1);
    else if (pop && !accept) credits_d = credits_q + CW'(1);
    // Every accepted tile leaves the tree exactly once, whatever the state.
    if (accept && !tree_vld)      inflight_d = inflight_q + CW'(1);
    else if (!accept && tree_vld) inflight_d = inflight_q - CW'(1);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          tiles_d     = cfg_clamp;
          tiles_in_d  = '0;
          tiles_wr_d  = '0;
          tiles_pop_d = '0;
          state_d     = (cfg_clamp == '0) ? DONE : RUN;
        end
      end
      RUN:   if (tiles_in_d == tiles_q) state_d = DRAIN;
      DRAIN: if (tiles_pop_q == tiles_q) state_d = DONE;
      DONE:  state_d = IDLE;
      FLUSH: begin
        if (tree_vld && (discard_q != '0)) discard_d = discard_q - CW'(1);
        if (discard_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A result leaving the tree on the abort edge is dropped there, not in FLUSH.
    if (abort_eff) begin
      state_d   = FLUSH;
      credits_d = CW'(FIFO_DEPTH);
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      discard_d = inflight_q - CW'(tree_vld);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tiles_q     <= '0;
      tiles_in_q  <= '0;
      tiles_wr_q  <= '0;
      tiles_pop_q <= '0;
      credits_q   <= CW'(FIFO_DEPTH);
      inflight_q  <= '0;
      discard_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tile_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tiles_q     <= tiles_d;
      tiles_in_q  <= tiles_in_d;
      tiles_wr_q  <= tiles_wr_d;
      tiles_pop_q <= tiles_pop_d;
      credits_q   <= credits_d;
      inflight_q  <= inflight_d;
      discard_q   <= discard_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tile_vld_q  <= accept;
    end
  end

  // Input register stage: accepted tile held for the tree.
  always_ff @(posedge clk) begin
    if (accept) tile_q <= bus.in_data;
  end

  fp16_adder_tree #(.N(N), .DW(DW), .ADD_LAT(ADD_LAT)) u_tree (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (tile_vld_q),
    .data_i (tile_q),
    .vld_o  (tree_vld),
    .data_o (tree_data)
  );

  // Tree output stage: result and its last flag land in the FIFO.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wr_ptr_q[AW-1:0]]  <= tree_data;
      last_q[wr_ptr_q[AW-1:0]] <= last_wr;
    end
  end

endmodule

// File: tb/tb_fp16_tile_reduce_stream.sv
module tb_fp16_tile_reduce_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, start4, abort4, busy4, done4;
  logic [6:0] cfg4;
  logic       rst128, start128, abort128, busy128, done128;
  logic [6:0] cfg128;

  fp16_tile_reduce_stream_if #(.N(4),   .DW(16)) bus4 ();
  fp16_tile_reduce_stream_if #(.N(128), .DW(16)) bus128 ();

  fp16_tile_reduce_stream #(.N(4), .DW(16), .ADD_LAT(11), .MAX_TILES(64), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst4), .start(start4), .cfg_tiles(cfg4), .abort(abort4),
    .bus(bus4), .busy(busy4), .done(done4));

  fp16_tile_reduce_stream #(.N(128), .DW(16), .ADD_LAT(11), .MAX_TILES(64), .FIFO_DEPTH(8)) u_dut128 (
    .clk(clk), .rst(rst128), .start(start128), .cfg_tiles(cfg128), .abort(abort128),
    .bus(bus128), .busy(busy128), .done(done128));

  localparam logic [63:0] T1 = 64'h4400_4200_4000_3C00;  // 1+2+3+4
  localparam logic [63:0] T2 = 64'hFBFF_FBFF_7BFF_7BFF;  // (+Inf)+(-Inf)

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] x3(input int j);
    return 16'h3C00 + 16'(j * 17);
  endfunction

  task automatic start4_run(input logic [6:0] n);
    start4 = 1'b1; cfg4 = n;
    tick();
    start4 = 1'b0;
  endtask

  task automatic send4(input logic [63:0] d);
    int c;
    c = 0;
    bus4.in_valid = 1'b1; bus4.in_data = d;
    while (!bus4.in_ready && c < 100) begin tick(); c++; end
    if (c >= 100) check("send4_timeout", 0, 1);
    tick();
    bus4.in_valid = 1'b0;
  endtask

  task automatic wait_out4(output int cyc);
    cyc = 0;
    while (!bus4.out_valid && cyc < 200) begin tick(); cyc++; end
    if (!bus4.out_valid) check("out4_timeout", 0, 1);
  endtask

  task automatic wait_done4();
    int c;
    c = 0;
    while (!done4 && c < 300) begin tick(); c++; end
    check("done4_seen", done4, 1);
    tick();
  endtask

  task automatic send128(input logic [2047:0] d);
    int c;
    c = 0;
    bus128.in_valid = 1'b1; bus128.in_data = d;
    while (!bus128.in_ready && c < 100) begin tick(); c++; end
    if (c >= 100) check("send128_timeout", 0, 1);
    tick();
    bus128.in_valid = 1'b0;
  endtask

  initial begin
    int cyc, acc, got, bc, ovs, dns;
    logic rdy, ov, ol;
    logic [15:0] od;

    rst4 = 1'b1; start4 = 1'b0; cfg4 = '0; abort4 = 1'b0;
    rst128 = 1'b1; start128 = 1'b0; cfg128 = '0; abort128 = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b1;
    bus128.in_valid = 1'b0; bus128.in_data = '0; bus128.out_ready = 1'b0;
    repeat (3) tick();

    check("rst_out_valid", bus4.out_valid, 0);
    check("rst_out_data",  bus4.out_data, 0);
    check("rst_in_ready",  bus4.in_ready, 0);
    check("rst_busy",      busy4, 0);
    check("rst_done",      done4, 0);
    rst4 = 1'b0; rst128 = 1'b0;
    tick();

    // 1: single tile, latency, done timing
    start4_run(7'd1);
    check("t1_in_ready", bus4.in_ready, 1);
    check("t1_busy", busy4, 1);
    send4(T1);
    wait_out4(cyc);
    check("t1_latency", cyc, 23);
    check("t1_data", bus4.out_data, 16'h4900);
    check("t1_last", bus4.out_last, 1);
    tick();
    check("t1_popped", bus4.out_valid, 0);
    check("t1_done_early", done4, 0);
    tick();
    check("t1_done", done4, 1);
    tick();
    check("t1_done_pulse", done4, 0);
    check("t1_idle", busy4, 0);

    // 2: pairing order -> Inf + -Inf = NaN
    start4_run(7'd1);
    send4(T2);
    wait_out4(cyc);
    check("t2_nan_exp", bus4.out_data[14:10], 5'h1F);
    check("t2_nan_mant_nz", (bus4.out_data[9:0] != 10'h0), 1);
    wait_done4();

    // 3: credit backpressure then ordered drain
    bus4.out_ready = 1'b0;
    start4_run(7'd10);
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      bus4.in_valid = (acc < 10);
      bus4.in_data  = {16'h0000, 16'h0000, x3(acc), x3(acc)};
      #1;
      rdy = bus4.in_ready;
      tick();
      if (rdy) acc++;
    end
    check("t3_accepts", acc, 4);
    check("t3_stalled", bus4.in_ready, 0);
    check("t3_fifo_full_valid", bus4.out_valid, 1);
    bus4.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 300 && got < 10; c++) begin
      bus4.in_valid = (acc < 10);
      bus4.in_data  = {16'h0000, 16'h0000, x3(acc), x3(acc)};
      #1;
      rdy = bus4.in_ready; ov = bus4.out_valid; od = bus4.out_data; ol = bus4.out_last;
      tick();
      if (rdy) acc++;
      if (ov) begin
        check($sformatf("t3_data%0d", got), od, x3(got) + 16'h0400);
        check($sformatf("t3_last%0d", got), ol, (got == 9));
        got++;
      end
    end
    bus4.in_valid = 1'b0;
    check("t3_count", got, 10);
    wait_done4();

    // 4: abort with three tiles in flight
    start4_run(7'd8);
    send4(T1); send4(T1); send4(T1);
    repeat (4) tick();
    abort4 = 1'b1;
    tick();
    abort4 = 1'b0;
    bc = 0; ovs = 0; dns = 0;
    for (int c = 0; c < 60; c++) begin
      if (!busy4) break;
      bc++;
      if (bus4.out_valid) ovs++;
      if (done4) dns++;
      tick();
    end
    check("t4_flush_cycles", bc, 19);
    check("t4_no_out_valid", ovs, 0);
    check("t4_no_done", dns, 0);
    check("t4_idle_out_valid", bus4.out_valid, 0);
    start4_run(7'd1);
    send4(T1);
    wait_out4(cyc);
    check("t4_next_data", bus4.out_data, 16'h4900);
    check("t4_next_last", bus4.out_last, 1);
    wait_done4();

    // 5: zero-tile run
    start4_run(7'd0);
    check("t5_done", done4, 1);
    check("t5_in_ready", bus4.in_ready, 0);
    tick();
    check("t5_done_pulse", done4, 0);
    check("t5_in_ready2", bus4.in_ready, 0);

    // 6: N=128, asynchronous reset mid-run, then fresh run
    start128 = 1'b1; cfg128 = 7'd2;
    tick();
    start128 = 1'b0;
    send128({128{16'h3C00}});
    cyc = 0;
    while (!bus128.out_valid && cyc < 200) begin tick(); cyc++; end
    check("t6_pre_valid", bus128.out_valid, 1);
    check("t6_pre_data", bus128.out_data, 16'h5800);
    check("t6_pre_busy", busy128, 1);
    #2;
    rst128 = 1'b1;
    #1;
    check("t6_rst_out_valid", bus128.out_valid, 0);
    check("t6_rst_out_data", bus128.out_data, 0);
    check("t6_rst_out_last", bus128.out_last, 0);
    check("t6_rst_in_ready", bus128.in_ready, 0);
    check("t6_rst_busy", busy128, 0);
    check("t6_rst_done", done128, 0);
    tick();
    rst128 = 1'b0;
    tick();
    bus128.out_ready = 1'b1;
    start128 = 1'b1; cfg128 = 7'd2;
    tick();
    start128 = 1'b0;
    send128({128{16'h3C00}});
    send128({128{16'h3C00}});
    got = 0;
    for (int c = 0; c < 200 && got < 2; c++) begin
      ov = bus128.out_valid; od = bus128.out_data; ol = bus128.out_last;
      tick();
      if (ov) begin
        check($sformatf("t6_data%0d", got), od, 16'h5800);
        check($sformatf("t6_last%0d", got), ol, (got == 1));
        got++;
      end
    end
    check("t6_count", got, 2);
    cyc = 0;
    while (!done128 && cyc < 50) begin tick(); cyc++; end
    check("t6_done", done128, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
